digit_serial_sub: RTL and testbench



---
 rtl/sub_pkg.sv | 23 ++
 rtl/digit_serial_sub_fs_chain.sv | 33 +++
 rtl/digit_serial_sub.sv | 155 +++++++++++++++
 tb/tb_digit_serial_sub.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared state encodings, FSM type and counter-width helper for digit_serial_sub.
// The optional SUB_OVF_EN macro adds the signed-overflow output.
package sub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    DONE = ST_DONE
  } sub_state_t;

  function automatic int cnt_width(input int ndig);
    if (ndig > 1) begin
      return $clog2(ndig);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/digit_serial_sub_fs_chain.sv
// Combinational ripple of DIGIT full-subtractor cells, LSB cell first.
// With SUB_OVF_EN the borrow entering the top cell is exported for overflow detection.
module fs_chain #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
`ifdef SUB_OVF_EN
  ,
  output logic             bmsb_in
`endif
);

  // Borrow ripples from cell 0 upward
  always_comb begin : chain
    logic [DIGIT:0] br;
    br    = '0;
    br[0] = bi;
    d     = '0;
    for (int i = 0; i < DIGIT; i++) begin
      d[i]    = x[i] ^ y[i] ^ br[i];
      br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
    end
    bo = br[DIGIT];
`ifdef SUB_OVF_EN
    bmsb_in = br[DIGIT-1];
`endif
  end

endmodule

// File: rtl/digit_serial_sub.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock, valid/ready on both sides.
// Define SUB_OVF_EN to add the two's-complement overflow output ovf.
module digit_serial_sub
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  sub_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, diff_sh_q, diff_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d, bout_q, bout_d;
  logic [DIGIT-1:0] dig_s;
  logic             bo_s, last_s;
  logic [WIDTH+DIGIT-1:0] cat_s;

  assign last_s = (cnt_q == LAST);
  // New digit enters at the top so the first (least significant) digit ends lowest
  assign cat_s  = {dig_s, diff_sh_q};

`ifdef SUB_OVF_EN
  logic ovf_q, ovf_d, bmsb_s;
`endif

  fs_chain #(.DIGIT(DIGIT)) u_chain (
    .x  (a_sh_q[DIGIT-1:0]),
    .y  (b_sh_q[DIGIT-1:0]),
    .bi (brw_q),
    .d  (dig_s),
    .bo (bo_s)
`ifdef SUB_OVF_EN
    ,
    .bmsb_in (bmsb_s)
`endif
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = BUSY; else state_d = IDLE;
      BUSY: if (last_s) state_d = DONE; else state_d = BUSY;
      DONE: if (out_ready) state_d = IDLE; else state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the state register
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath next-state: load, shift one digit, capture result on the last digit
  always_comb begin
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    diff_sh_d = diff_sh_q;
    brw_d     = brw_q;
    cnt_d     = cnt_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
`ifdef SUB_OVF_EN
    ovf_d     = ovf_q;
`endif
    if ((state_q == IDLE) && in_valid) begin
      a_sh_d = a;
      b_sh_d = b;
      brw_d  = bin;
      cnt_d  = '0;
    end else if (state_q == BUSY) begin
      a_sh_d    = a_sh_q >> DIGIT;
      b_sh_d    = b_sh_q >> DIGIT;
      diff_sh_d = cat_s[WIDTH+DIGIT-1:DIGIT];
      brw_d     = bo_s;
      if (last_s) begin
        cnt_d  = '0;
        diff_d = cat_s[WIDTH+DIGIT-1:DIGIT];
        bout_d = bo_s;
`ifdef SUB_OVF_EN
        ovf_d  = bmsb_s ^ bo_s;
`endif
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      brw_q     <= 1'b0;
      cnt_q     <= '0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      diff_sh_q <= diff_sh_d;
      brw_q     <= brw_d;
      cnt_q     <= cnt_d;
      diff_q    <= diff_d;
      bout_q    <= bout_d;
`ifdef SUB_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_sub.sv
// Directed bench for digit_serial_sub: four instances (8/2, 1/1, 16/4, 8/8) share stimulus buses.
// Define SUB_OVF_EN to also check the ovf output.
module tb_digit_serial_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a_s, b_s;
  logic        bin_s, orr;
  logic [3:0]  iv, ir, ov, bo;
  logic [7:0]  d0, d3;
  logic [0:0]  d1;
  logic [15:0] d2;
`ifdef SUB_OVF_EN
  logic [3:0]  of;
`endif
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  digit_serial_sub #(.WIDTH(8), .DIGIT(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_s[7:0]), .b(b_s[7:0]),
    .bin(bin_s), .out_valid(ov[0]), .out_ready(orr), .diff(d0), .bout(bo[0])
`ifdef SUB_OVF_EN
    , .ovf(of[0])
`endif
  );
  digit_serial_sub #(.WIDTH(1), .DIGIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_s[0:0]), .b(b_s[0:0]),
    .bin(bin_s), .out_valid(ov[1]), .out_ready(orr), .diff(d1), .bout(bo[1])
`ifdef SUB_OVF_EN
    , .ovf(of[1])
`endif
  );
  digit_serial_sub #(.WIDTH(16), .DIGIT(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_s), .b(b_s),
    .bin(bin_s), .out_valid(ov[2]), .out_ready(orr), .diff(d2), .bout(bo[2])
`ifdef SUB_OVF_EN
    , .ovf(of[2])
`endif
  );
  digit_serial_sub #(.WIDTH(8), .DIGIT(8)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .a(a_s[7:0]), .b(b_s[7:0]),
    .bin(bin_s), .out_valid(ov[3]), .out_ready(orr), .diff(d3), .bout(bo[3])
`ifdef SUB_OVF_EN
    , .ovf(of[3])
`endif
  );

  function automatic logic [15:0] dsel(input int k);
    case (k)
      0: return {8'h00, d0};
      1: return {15'h0000, d1};
      2: return d2;
      default: return {8'h00, d3};
    endcase
  endfunction

  function automatic int wsel(input int k);
    case (k)
      0: return 8;
      1: return 1;
      2: return 16;
      default: return 8;
    endcase
  endfunction

  // Signed overflow reference: true when the exact signed a - b - bin leaves the w-bit range
  function automatic logic ovf_ref(input int w, input logic [15:0] a, input logic [15:0] b, input logic bi);
    longint ua, ub, sa, sb, r, lim;
    ua  = longint'(a) & ((longint'(1) << w) - 1);
    ub  = longint'(b) & ((longint'(1) << w) - 1);
    lim = longint'(1) << (w - 1);
    sa  = (ua >= lim) ? ua - (lim << 1) : ua;
    sb  = (ub >= lim) ? ub - (lim << 1) : ub;
    r   = sa - sb - longint'(bi);
    return (r < -lim) || (r >= lim);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on instance k; caller is 1 time unit after a clock edge with the DUT idle
  task automatic tx(input int k, input logic [15:0] a, input logic [15:0] b, input logic bi,
                    input logic [15:0] ed, input logic eb, input int elat, input int hold);
    int lat;
    chk("in_ready_idle", {15'h0000, ir[k]}, 16'h0001);
    a_s = a; b_s = b; bin_s = bi; iv[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    a_s = ~a; b_s = ~b; bin_s = ~bi;
    chk("in_ready_busy", {15'h0000, ir[k]}, 16'h0000);
    lat = 0;
    while (!ov[k] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 16'(lat), 16'(elat));
    chk("diff", dsel(k), ed);
    chk("bout", {15'h0000, bo[k]}, {15'h0000, eb});
`ifdef SUB_OVF_EN
    chk("ovf", {15'h0000, of[k]}, {15'h0000, ovf_ref(wsel(k), a, b, bi)});
`endif
    for (int h = 0; h < hold; h++) begin
      iv[k] = 1'b1;
      a_s = 16'($urandom); b_s = 16'($urandom);
      @(posedge clk); #1;
      chk("bp_out_valid", {15'h0000, ov[k]}, 16'h0001);
      chk("bp_in_ready", {15'h0000, ir[k]}, 16'h0000);
      chk("bp_diff", dsel(k), ed);
      chk("bp_bout", {15'h0000, bo[k]}, {15'h0000, eb});
    end
    iv[k] = 1'b0;
    orr = 1'b1;
    @(posedge clk); #1;
    orr = 1'b0;
    chk("release_out_valid", {15'h0000, ov[k]}, 16'h0000);
    chk("release_in_ready", {15'h0000, ir[k]}, 16'h0001);
  endtask

  initial begin
    logic [7:0]  tbl_d, tbl_b;
    logic [2:0]  v;
    logic [15:0] ra, rb;
    logic        rbi;
    rst_n = 1'b0; iv = 4'h0; orr = 1'b0; a_s = 16'h0000; b_s = 16'h0000; bin_s = 1'b0;
    #2;
    chk("rst_out_valid", {12'h000, ov}, 16'h0000);
    chk("rst_diff", dsel(0), 16'h0000);
    chk("rst_bout", {12'h000, bo}, 16'h0000);
`ifdef SUB_OVF_EN
    chk("rst_ovf", {12'h000, of}, 16'h0000);
`endif
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {12'h000, ir}, 16'h000F);

    tx(0, 16'h0035, 16'h0012, 1'b0, 16'h0023, 1'b0, 4, 5);
    tx(0, 16'h0000, 16'h0001, 1'b0, 16'h00FF, 1'b1, 4, 0);
    tx(0, 16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 4, 0);
    tx(0, 16'h0044, 16'h0044, 1'b1, 16'h00FF, 1'b1, 4, 0);
    tx(0, 16'h0080, 16'h0001, 1'b0, 16'h007F, 1'b0, 4, 0);
`ifdef SUB_OVF_EN
    chk("ovf_80_01", {15'h0000, of[0]}, 16'h0001);
`endif
    tx(0, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 4, 0);
`ifdef SUB_OVF_EN
    chk("ovf_05_03", {15'h0000, of[0]}, 16'h0000);
`endif
    tx(3, 16'h0044, 16'h0044, 1'b1, 16'h00FF, 1'b1, 1, 0);
    tx(3, 16'h00A5, 16'h005A, 1'b0, 16'h004B, 1'b0, 1, 2);

    // Abort in the second BUSY cycle; the previous result (0x02) must clear asynchronously
    a_s = 16'h0077; b_s = 16'h0011; bin_s = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {15'h0000, ov[0]}, 16'h0000);
    chk("abort_diff", dsel(0), 16'h0000);
    chk("abort_bout", {15'h0000, bo[0]}, 16'h0000);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_result", {15'h0000, ov[0]}, 16'h0000);
    chk("abort_in_ready", {15'h0000, ir[0]}, 16'h0001);
    tx(0, 16'h0009, 16'h0004, 1'b0, 16'h0005, 1'b0, 4, 0);

    // Full-subtractor truth table, index {a,b,bin}
    tbl_d = 8'b1001_0110;
    tbl_b = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      tx(1, {15'h0000, v[2]}, {15'h0000, v[1]}, v[0], {15'h0000, tbl_d[i]}, tbl_b[i], 1, 0);
    end

    for (int i = 0; i < 1000; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rbi = 1'($urandom);
      tx(2, ra, rb, rbi, ra - rb - {15'h0000, rbi},
         ({1'b0, ra} < ({1'b0, rb} + {16'h0000, rbi})), 4, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
